ahb_slave_write_bank: RTL and testbench
=======================================

// Module: ahb_slave_write_bank
// PURPOSE
//   Parametrised AHB-Lite write-only slave for the AES front end. Assembles 32-bit HWDATA beats into
//   NUM_CH wide channel registers (key, nonce, destination, plaintext in the default build).
//   Signals completion per channel. Back-pressures the bus with wait states when the completed
//   PUSH_CH channel cannot enter the downstream FIFO. Returns AHB ERROR on illegal accesses.
// PARAMETERS
//   NUM_CH     4           number of channel registers
//   CH_WIDTH   128         bits per channel; multiple of 32, CH_WIDTH/8 a power of two
//   BASE_ADDR  32'h0000_0000  byte address of channel 0 word 0
//   PUSH_CH    3           channel whose completion pushes the downstream FIFO (plaintext)
// PORTS
//   HCLK       in   1                 bus clock; all state on rising edge
//   HRESET     in   1                 asynchronous, active-high reset
//   HSEL       in   1                 slave select
//   HADDR      in   32                byte address
//   HWRITE     in   1                 1 = write
//   HTRANS     in   2                 IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
//   HSIZE      in   3                 must be 3'b010 (word)
//   HBURST     in   3                 accepted, not decoded; address taken per beat
//   HWDATA     in   32                write data, data phase
//   HREADY     in   1                 bus-level ready (address-phase qualifier)
//   HREADYOUT  out  1                 slave ready
//   HRESP      out  1                 0 OKAY, 1 ERROR
//   fifo_full  in   1                 downstream FIFO full
//   fifo_push  out  1                 one-cycle push of PUSH_CH data
//   ch_data    out  NUM_CH*CH_WIDTH   channel c at [c*CH_WIDTH +: CH_WIDTH]
//   ch_valid   out  NUM_CH            one-cycle pulse: channel's last word written
//   rw_error   out  1                 one-cycle pulse on every ERROR response
// BEHAVIOUR
//   Reset: ch_data=0, ch_valid=0, fifo_push=0, rw_error=0, HREADYOUT=1, HRESP=0, state IDLE.
//   Address phase is captured only when HSEL & HREADY & HTRANS[1]. BUSY and IDLE get zero-wait OKAY.
//   Decode: off=HADDR-BASE_ADDR; ch=off/(CH_WIDTH/8); word=off[log2(CH_WIDTH/8)-1:2]; word 0 = LSBs.
//   Illegal if any of: HWRITE=0; HSIZE!=010; HADDR[1:0]!=0; off>=NUM_CH*CH_WIDTH/8 (unsigned, wraps).
//   States:
//     IDLE : no data phase pending. Legal capture -> DATA. Illegal capture -> ERR1.
//     DATA : write HWDATA into ch_data[ch][word*32 +: 32]; HREADYOUT=1.
//            If ch==PUSH_CH, word is last, and fifo_full=1: no write, HREADYOUT=0 -> WAIT.
//            Otherwise the write completes. Next state as IDLE's decode of the pipelined address phase.
//     WAIT : HREADYOUT=0 while fifo_full=1. When fifo_full=0: write, HREADYOUT=1, -> IDLE.
//            No new capture in WAIT (HREADY low). HWDATA is sampled on the completing cycle.
//     ERR1 : HREADYOUT=0, HRESP=1, rw_error=1 -> ERR2.
//     ERR2 : HREADYOUT=1, HRESP=1; no register changes. Next address phase decoded as in IDLE.
//   Completion: writing word CH_WIDTH/32-1 of channel c sets ch_valid[c]=1 in the next cycle.
//     For c==PUSH_CH, fifo_push=1 in that same cycle; ch_data is already updated.
//     Words may be written in any order. Only the last-word write fires ch_valid.
//     Rewriting any word just overwrites it.
//   Back-to-back pipelined NONSEQ/SEQ beats run at zero wait except the WAIT case above.
//   A push never happens while fifo_full=1. At most one push per completion.
//   HRESET mid-WAIT or mid-ERR: immediate return to reset values; the pending write and push are dropped.
// TESTING
//   Reset: HRESET=1 then release -> HREADYOUT=1, HRESP=0, all ch_data=0, no pulses.
//   INCR4 burst at BASE+0x00..0x0C, data 1,2,3,4
//     -> ch_data[127:0]=0x00000004_00000003_00000002_00000001; ch_valid=4'b0001 one cycle; 0 waits.
//   Plaintext write at 0x3C with fifo_full=1 for 3 cycles -> HREADYOUT low 3 cycles.
//     Then write completes, ch_valid[3]=1 and fifo_push=1 together, exactly once.
//   Write at 0x40 (out of range); then HSIZE=000 at 0x00; then a read at 0x00
//     -> each gets two-cycle ERROR (HREADYOUT 0 then 1, HRESP 1 both) and rw_error=1.
//     ch_data is unchanged.
//   Word order 3,1,0,2 on channel 1 -> ch_valid[1] only after the 0x1C write.
//     Then rewrite 0x10 -> no ch_valid pulse.
//   HRESET asserted during WAIT -> all outputs return to reset values; no fifo_push after release.

Source files
------------

// File: rtl/ahb_slave_write_bank.sv
// AHB-Lite write-only slave that assembles 32-bit beats into wide channel registers,
// stalling the bus when the pushing channel completes into a full downstream FIFO.
module ahb_slave_write_bank #(
  parameter int          NUM_CH    = 4,
  parameter int          CH_WIDTH  = 128,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          PUSH_CH   = 3
) (
  input  logic                       HCLK,
  input  logic                       HRESET,
  input  logic                       HSEL,
  input  logic [31:0]                HADDR,
  input  logic                       HWRITE,
  input  logic [1:0]                 HTRANS,
  input  logic [2:0]                 HSIZE,
  input  logic [2:0]                 HBURST,
  input  logic [31:0]                HWDATA,
  input  logic                       HREADY,
  output logic                       HREADYOUT,
  output logic                       HRESP,
  input  logic                       fifo_full,
  output logic                       fifo_push,
  output logic [NUM_CH*CH_WIDTH-1:0] ch_data,
  output logic [NUM_CH-1:0]          ch_valid,
  output logic                       rw_error
);

  localparam int WPC = CH_WIDTH / 32;
  localparam int BW  = $clog2(CH_WIDTH / 8);
  localparam int WW  = (WPC > 1) ? $clog2(WPC) : 1;
  localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [31:0]   SPAN      = 32'(NUM_CH * CH_WIDTH / 8);
  localparam logic [WW-1:0] LAST_WORD = WW'(WPC - 1);
  localparam logic [CW-1:0] PUSH_IDX  = CW'(PUSH_CH);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] DATA = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] ERR1 = 3'd3;
  localparam logic [2:0] ERR2 = 3'd4;

  logic [2:0]    state, state_nxt, decode_nxt;
  logic [CW-1:0] pend_ch, cap_ch;
  logic [WW-1:0] pend_word, cap_word;
  logic [31:0]   off;
  logic          capture, legal, last_beat, stall, do_write;
  logic          unused_ok;

  // HBURST is ignored: every beat carries its own address.
  assign unused_ok = ^{HBURST, HTRANS[0]};

  assign off        = HADDR - BASE_ADDR;
  assign capture    = HSEL & HREADY & HTRANS[1];
  assign legal      = HWRITE && (HSIZE == 3'b010) && (HADDR[1:0] == 2'b00) && (off < SPAN);
  assign cap_ch     = CW'(off >> BW);
  assign cap_word   = WW'((off >> 2) & 32'(WPC - 1));
  assign decode_nxt = capture ? (legal ? DATA : ERR1) : IDLE;

  assign last_beat = (pend_word == LAST_WORD);
  assign stall     = (state == DATA) && (pend_ch == PUSH_IDX) && last_beat && fifo_full;
  assign do_write  = ((state == DATA) && !stall) || ((state == WAIT) && !fifo_full);
  assign rw_error  = (state == ERR1);

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: state_nxt = decode_nxt;
      DATA: begin
        HREADYOUT = !stall;
        state_nxt = stall ? WAIT : decode_nxt;
      end
      WAIT: begin
        HREADYOUT = !fifo_full;
        state_nxt = fifo_full ? WAIT : IDLE;
      end
      ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_nxt = ERR2;
      end
      ERR2: begin
        HRESP     = 1'b1;
        state_nxt = decode_nxt;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Only the decode paths reach DATA, so entering DATA is the capture strobe.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= IDLE;
      pend_ch   <= '0;
      pend_word <= '0;
      ch_data   <= '0;
      ch_valid  <= '0;
      fifo_push <= 1'b0;
    end else begin
      state     <= state_nxt;
      ch_valid  <= '0;
      fifo_push <= 1'b0;
      if (state_nxt == DATA) begin
        pend_ch   <= cap_ch;
        pend_word <= cap_word;
      end
      if (do_write) begin
        ch_data[int'(pend_ch) * CH_WIDTH + int'(pend_word) * 32 +: 32] <= HWDATA;
        if (last_beat) begin
          ch_valid[pend_ch] <= 1'b1;
          fifo_push         <= (pend_ch == PUSH_IDX);
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_slave_write_bank.sv
// Table-driven bench for ahb_slave_write_bank: one row per bus cycle with hand-computed
// expected handshake/pulse outputs and optional channel-data checks.
module tb_ahb_slave_write_bank;

  localparam int NUM_CH   = 4;
  localparam int CH_WIDTH = 128;

  localparam logic [1:0] ID = 2'b00;
  localparam logic [1:0] BZ = 2'b01;
  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] SQ = 2'b11;
  localparam logic [2:0] W  = 3'b010;

  logic                       HCLK = 1'b0;
  logic                       HRESET;
  logic                       HSEL;
  logic [31:0]                HADDR;
  logic                       HWRITE;
  logic [1:0]                 HTRANS;
  logic [2:0]                 HSIZE;
  logic [2:0]                 HBURST;
  logic [31:0]                HWDATA;
  logic                       HREADY;
  logic                       HREADYOUT;
  logic                       HRESP;
  logic                       fifo_full;
  logic                       fifo_push;
  logic [NUM_CH*CH_WIDTH-1:0] ch_data;
  logic [NUM_CH-1:0]          ch_valid;
  logic                       rw_error;

  typedef struct {
    logic         rst;
    logic         sel;
    logic [1:0]   trans;
    logic [31:0]  addr;
    logic         wr;
    logic [2:0]   size;
    logic [31:0]  wdata;
    logic         full;
    logic         rdy;
    logic         resp;
    logic [3:0]   valid;
    logic         push;
    logic         err;
    logic         chk;
    int           chk_ch;
    logic [127:0] chk_data;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  ahb_slave_write_bank #(
    .NUM_CH   (NUM_CH),
    .CH_WIDTH (CH_WIDTH),
    .BASE_ADDR(32'h0000_0000),
    .PUSH_CH  (3)
  ) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .HSEL     (HSEL),
    .HADDR    (HADDR),
    .HWRITE   (HWRITE),
    .HTRANS   (HTRANS),
    .HSIZE    (HSIZE),
    .HBURST   (HBURST),
    .HWDATA   (HWDATA),
    .HREADY   (HREADY),
    .HREADYOUT(HREADYOUT),
    .HRESP    (HRESP),
    .fifo_full(fifo_full),
    .fifo_push(fifo_push),
    .ch_data  (ch_data),
    .ch_valid (ch_valid),
    .rw_error (rw_error)
  );

  // Single-slave system: the bus ready is this slave's ready.
  assign HREADY = HREADYOUT;

  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic add(input logic r, s, input logic [1:0] t, input logic [31:0] a,
                     input logic w, input logic [2:0] z, input logic [31:0] d, input logic f,
                     input logic ry, rp, input logic [3:0] v, input logic p, e);
    vec_t x;
    x.rst = r; x.sel = s; x.trans = t; x.addr = a; x.wr = w; x.size = z;
    x.wdata = d; x.full = f; x.rdy = ry; x.resp = rp; x.valid = v; x.push = p;
    x.err = e; x.chk = 1'b0; x.chk_ch = 0; x.chk_data = '0;
    vecs.push_back(x);
  endtask

  task automatic chk(input int ch, input logic [127:0] d);
    vecs[vecs.size()-1].chk      = 1'b1;
    vecs[vecs.size()-1].chk_ch   = ch;
    vecs[vecs.size()-1].chk_data = d;
  endtask

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    @(negedge HCLK);
    HRESET    = v.rst;
    HSEL      = v.sel;
    HTRANS    = v.trans;
    HADDR     = v.addr;
    HWRITE    = v.wr;
    HSIZE     = v.size;
    HWDATA    = v.wdata;
    fifo_full = v.full;
    #1;
  endtask

  initial begin
    HRESET = 1'b1; HSEL = 1'b0; HTRANS = ID; HADDR = '0; HWRITE = 1'b0;
    HSIZE = W; HBURST = 3'b011; HWDATA = '0; fifo_full = 1'b0;

    // Reset state
    repeat (2) @(negedge HCLK);
    #1;
    check_output("reset outs", 128'({HREADYOUT, HRESP, ch_valid, fifo_push, rw_error}),
                 128'({1'b1, 1'b0, 4'b0000, 1'b0, 1'b0}));
    for (int c = 0; c < NUM_CH; c++)
      check_output($sformatf("reset ch%0d", c), ch_data[c*CH_WIDTH +: CH_WIDTH], 128'h0);

    // INCR4 burst to channel 0, zero waits
    add(0,1,NS,32'h00,1,W,32'h0,0,        1,0,4'b0000,0,0);
    add(0,1,SQ,32'h04,1,W,32'h1,0,        1,0,4'b0000,0,0);
    add(0,1,SQ,32'h08,1,W,32'h2,0,        1,0,4'b0000,0,0);
    add(0,1,SQ,32'h0C,1,W,32'h3,0,        1,0,4'b0000,0,0);
    add(0,0,ID,32'h00,0,W,32'h4,0,        1,0,4'b0000,0,0);
    add(0,0,ID,32'h00,0,W,32'h0,0,        1,0,4'b0001,0,0);
    chk(0, 128'h00000004_00000003_00000002_00000001);
    add(0,0,ID,32'h00,0,W,32'h0,0,        1,0,4'b0000,0,0);

    // Plaintext last word with FIFO full for three cycles
    add(0,1,NS,32'h3C,1,W,32'h0,0,        1,0,4'b0000,0,0);
    add(0,0,ID,32'h00,0,W,32'hCAFEF00D,1, 0,0,4'b0000,0,0);
    add(0,0,ID,32'h00,0,W,32'hCAFEF00D,1, 0,0,4'b0000,0,0);
    add(0,0,ID,32'h00,0,W,32'hCAFEF00D,1, 0,0,4'b0000,0,0);
    add(0,0,ID,32'h00,0,W,32'hCAFEF00D,0, 1,0,4'b0000,0,0);
    add(0,0,ID,32'h00,0,W,32'h0,0,        1,0,4'b1000,1,0);
    chk(3, {32'hCAFEF00D, 96'h0});
    add(0,0,ID,32'h00,0,W,32'h0,0,        1,0,4'b0000,0,0);

    // Error responses: out of range, bad size, read, misaligned
    add(0,1,NS,32'h40,1,W,32'h0,0,        1,0,4'b0000,0,0);
    add(0,0,ID,32'h00,0,W,32'h0,0,        0,1,4'b0000,0,1);
    add(0,1,NS,32'h00,1,3'b000,32'h0,0,   1,1,4'b0000,0,0);
    add(0,0,ID,32'h00,0,W,32'hDEADBEEF,0, 0,1,4'b0000,0,1);
    add(0,1,NS,32'h00,0,W,32'hDEADBEEF,0, 1,1,4'b0000,0,0);
    add(0,0,ID,32'h00,0,W,32'hDEADBEEF,0, 0,1,4'b0000,0,1);
    add(0,0,ID,32'h00,0,W,32'hDEADBEEF,0, 1,1,4'b0000,0,0);
    add(0,0,ID,32'h00,0,W,32'h0,0,        1,0,4'b0000,0,0);
    chk(0, 128'h00000004_00000003_00000002_00000001);
    add(0,1,NS,32'h06,1,W,32'h0,0,        1,0,4'b0000,0,0);
    add(0,0,ID,32'h00,0,W,32'h0BAD0BAD,0, 0,1,4'b0000,0,1);
    add(0,0,ID,32'h00,0,W,32'h0BAD0BAD,0, 1,1,4'b0000,0,0);
    add(0,0,ID,32'h00,0,W,32'h0,0,        1,0,4'b0000,0,0);
    chk(0, 128'h00000004_00000003_00000002_00000001);

    // Unselected and BUSY transfers are ignored
    add(0,0,NS,32'h00,1,W,32'h0,0,        1,0,4'b0000,0,0);
    add(0,1,BZ,32'h04,1,W,32'hFFFFFFFF,0, 1,0,4'b0000,0,0);
    add(0,0,ID,32'h00,0,W,32'hFFFFFFFF,0, 1,0,4'b0000,0,0);
    chk(0, 128'h00000004_00000003_00000002_00000001);

    // Channel 1 written in word order 3,1,0,2, then word 0 rewritten
    add(0,1,NS,32'h1C,1,W,32'h0,0,        1,0,4'b0000,0,0);
    add(0,1,NS,32'h14,1,W,32'h11,0,       1,0,4'b0000,0,0);
    add(0,1,NS,32'h10,1,W,32'h12,0,       1,0,4'b0010,0,0);
    add(0,1,NS,32'h18,1,W,32'h13,0,       1,0,4'b0000,0,0);
    add(0,0,ID,32'h00,0,W,32'h14,0,       1,0,4'b0000,0,0);
    add(0,0,ID,32'h00,0,W,32'h0,0,        1,0,4'b0000,0,0);
    chk(1, {32'h11, 32'h14, 32'h12, 32'h13});
    add(0,1,NS,32'h10,1,W,32'h0,0,        1,0,4'b0000,0,0);
    add(0,0,ID,32'h00,0,W,32'h55,0,       1,0,4'b0000,0,0);
    add(0,0,ID,32'h00,0,W,32'h0,0,        1,0,4'b0000,0,0);
    chk(1, {32'h11, 32'h14, 32'h12, 32'h55});

    // Reset asserted while stalled in WAIT
    add(0,1,NS,32'h3C,1,W,32'h0,0,        1,0,4'b0000,0,0);
    add(0,0,ID,32'h00,0,W,32'h12345678,1, 0,0,4'b0000,0,0);
    add(0,0,ID,32'h00,0,W,32'h12345678,1, 0,0,4'b0000,0,0);
    add(1,0,ID,32'h00,0,W,32'h12345678,1, 1,0,4'b0000,0,0);
    chk(3, 128'h0);
    add(0,0,ID,32'h00,0,W,32'h12345678,0, 1,0,4'b0000,0,0);
    add(0,0,ID,32'h00,0,W,32'h0,0,        1,0,4'b0000,0,0);
    add(0,0,ID,32'h00,0,W,32'h0,0,        1,0,4'b0000,0,0);
    chk(1, 128'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d outs", i),
                   128'({HREADYOUT, HRESP, ch_valid, fifo_push, rw_error}),
                   128'({vecs[i].rdy, vecs[i].resp, vecs[i].valid, vecs[i].push, vecs[i].err}));
      if (vecs[i].chk)
        check_output($sformatf("vec%0d ch%0d data", i, vecs[i].chk_ch),
                     ch_data[vecs[i].chk_ch*CH_WIDTH +: CH_WIDTH], vecs[i].chk_data);
    end

    // After the mid-WAIT reset no push may surface and every channel stays cleared
    for (int k = 0; k < 4; k++) begin
      @(negedge HCLK);
      #1;
      check_output($sformatf("post-reset push %0d", k), 128'(fifo_push), 128'h0);
    end
    for (int c = 0; c < NUM_CH; c++)
      check_output($sformatf("post-reset ch%0d", c), ch_data[c*CH_WIDTH +: CH_WIDTH], 128'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
